nonce_search_ctrl: RTL

- Sequences the micro-hash datapath for the nonce-search (mining) system.
- Latches the 12-byte header and the 8-bit target, then issues one hash request per candidate nonce, starting at 0.
- Checks each hash result against the target and reports the first winning nonce, or reports exhaustion.
- Sits between the system top and the hash core; the system-level `finished` and `nonce_out` come from this block.

---
 rtl/nonce_search_pkg.sv | 23 ++
 rtl/nonce_search_cmp.sv | 23 ++
 rtl/nonce_search_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/nonce_search_pkg.sv
// Shared types and constants for the nonce-search controller and its comparator.
package nonce_search_pkg;

  localparam int DATA_BYTES_DEF = 12;
  localparam int NONCE_W_DEF    = 32;
  localparam int HASH_W_DEF     = 24;
  localparam int HDR_W          = DATA_BYTES_DEF * 8;
  localparam int BLOCK_W        = HDR_W + NONCE_W_DEF;

  // The two hash bytes that must both fall strictly below the target.
  localparam int HASH_B0_MSB = 23;
  localparam int HASH_B1_MSB = 15;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    FOUND = 3'd4,
    FAIL  = 3'd5
  } state_t;

endpackage

// File: rtl/nonce_search_cmp.sv
// Combinational pass check: both upper hash bytes strictly below the target.
module nonce_search_cmp
  import nonce_search_pkg::*;
#(
  parameter int HASH_W = HASH_W_DEF
) (
  input  logic [HASH_W-1:0] hash_value,
  input  logic [7:0]        target,
  output logic              pass
);

  logic [7:0] byte0;
  logic [7:0] byte1;
  logic       unused_low;

  assign byte0      = hash_value[HASH_B0_MSB -: 8];
  assign byte1      = hash_value[HASH_B1_MSB -: 8];
  assign unused_low = ^hash_value[HASH_B1_MSB-8:0];

  // Equality fails, so target=0 can never pass.
  assign pass = (byte0 < target) && (byte1 < target);

endmodule

// File: rtl/nonce_search_ctrl.sv
// Nonce-search sequencer: IDLE -> ISSUE -> WAIT -> CHECK -> (ISSUE | FOUND | FAIL).
// One hash request per nonce from 0 up to MAX_NONCE; first pass wins.
module nonce_search_ctrl
  import nonce_search_pkg::*;
#(
  parameter int                   DATA_BYTES = DATA_BYTES_DEF,
  parameter int                   NONCE_W    = NONCE_W_DEF,
  parameter int                   HASH_W     = HASH_W_DEF,
  parameter logic [NONCE_W-1:0]   MAX_NONCE  = '1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [DATA_BYTES*8-1:0]         data_in,
  input  logic [7:0]                      target,
  output logic                            hash_start,
  output logic [DATA_BYTES*8+NONCE_W-1:0] hash_block,
  input  logic                            hash_done,
  input  logic [HASH_W-1:0]               hash_value,
  output logic                            busy,
  output logic                            finished,
  output logic                            exhausted,
  output logic [NONCE_W-1:0]              nonce_out
);

  localparam int HDR_L = DATA_BYTES * 8;

  state_t             state;
  logic [HDR_L-1:0]   hdr_q;
  logic [NONCE_W-1:0] nonce_q;
  logic [NONCE_W-1:0] nonce_nxt;
  logic [7:0]         tgt_q;
  logic [HASH_W-1:0]  hv_q;
  logic               pass;

  assign nonce_nxt = nonce_q + {{(NONCE_W-1){1'b0}}, 1'b1};

  nonce_search_cmp #(
    .HASH_W(HASH_W)
  ) u_cmp (
    .hash_value(hv_q),
    .target    (tgt_q),
    .pass      (pass)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      hash_start <= 1'b0;
      hash_block <= '0;
      busy       <= 1'b0;
      finished   <= 1'b0;
      exhausted  <= 1'b0;
      nonce_out  <= '0;
      hdr_q      <= '0;
      nonce_q    <= '0;
      tgt_q      <= '0;
      hv_q       <= '0;
    end else begin
      hash_start <= 1'b0;
      case (state)
        IDLE, FOUND, FAIL: begin
          if (start) begin
            hdr_q      <= data_in;
            tgt_q      <= target;
            nonce_q    <= '0;
            finished   <= 1'b0;
            exhausted  <= 1'b0;
            busy       <= 1'b1;
            // Request fields are loaded here so they are valid during ISSUE.
            hash_start <= 1'b1;
            hash_block <= {data_in, {NONCE_W{1'b0}}};
            state      <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (hash_done) begin
            hv_q  <= hash_value;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (pass) begin
            nonce_out <= nonce_q;
            finished  <= 1'b1;
            busy      <= 1'b0;
            state     <= FOUND;
          end else if (nonce_q == MAX_NONCE) begin
            nonce_out <= nonce_q;
            exhausted <= 1'b1;
            busy      <= 1'b0;
            state     <= FAIL;
          end else begin
            nonce_q    <= nonce_nxt;
            hash_start <= 1'b1;
            hash_block <= {hdr_q, nonce_nxt};
            state      <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
